// File: rtl/vram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vram_pkg
// Description : Shared types and helpers for the VRAM line responder.
// Revision    : 1.0 - initial release
// ============================================================================
package vram_pkg;

    localparam int LINE_BITS = 256;
    localparam int BEAT_BITS = 32;
    localparam int BEATS     = LINE_BITS / BEAT_BITS;
    localparam int BIDX_W    = $clog2(BEATS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD      = 2'd2,
        RD_LAST = 2'd3
    } state_t;

    function automatic logic [BEAT_BITS-1:0] beat_slice(
        input logic [LINE_BITS-1:0] line,
        input logic [BIDX_W-1:0]    b
    );
        return line[BEAT_BITS*b +: BEAT_BITS];
    endfunction

endpackage
`default_nettype wire

// File: rtl/vram_line_responder.sv
`default_nettype none
// ============================================================================
// Module      : vram_line_responder
// Description : Serialises 256-bit line requests into 32-bit SRAM beats.
// Revision    : 1.0 - initial release
// ============================================================================
module vram_line_responder
    import vram_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int LINE_W = 256,
    parameter int BEAT_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rden,
    input  logic                     wren,
    input  logic [ADDR_W-1:0]        address,
    input  logic [LINE_W/8-1:0]      byteena,
    input  logic [LINE_W-1:0]        writeData,
    output logic [LINE_W-1:0]        readData,
    output logic                     rvalid,
    output logic                     busy,
    output logic [ADDR_W+BIDX_W-1:0] mem_addr,
    output logic                     mem_we,
    output logic [BEAT_W/8-1:0]      mem_be,
    output logic [BEAT_W-1:0]        mem_wdata,
    input  logic [BEAT_W-1:0]        mem_rdata
);

    localparam int BE_W = BEAT_W / 8;

    state_t                     state_q,     state_d;
    logic [BIDX_W-1:0]          b_q,         b_d;
    logic [ADDR_W-1:0]          addr_q,      addr_d;
    logic [LINE_W/8-1:0]        be_q,        be_d;
    logic [LINE_W-1:0]          line_q,      line_d;
    logic [LINE_W-1:0]          asm_q,       asm_d;
    logic [LINE_W-1:0]          read_data_q, read_data_d;
    logic                       rvalid_q,    rvalid_d;
    logic [ADDR_W+BIDX_W-1:0]   mem_addr_q,  mem_addr_d;
    logic                       mem_we_q,    mem_we_d;
    logic [BE_W-1:0]            mem_be_q,    mem_be_d;
    logic [BEAT_W-1:0]          mem_wdata_q, mem_wdata_d;

    always_comb begin
        state_d     = state_q;
        b_d         = b_q;
        addr_d      = addr_q;
        be_d        = be_q;
        line_d      = line_q;
        asm_d       = asm_q;
        read_data_d = read_data_q;
        rvalid_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (wren) begin
                    addr_d  = address;
                    be_d    = byteena;
                    line_d  = writeData;
                    b_d     = '0;
                    state_d = WR;
                end else if (rden) begin
                    addr_d  = address;
                    b_d     = '0;
                    state_d = RD;
                end
            end
            WR: begin
                b_d = b_q + BIDX_W'(1);
                if (b_q == BIDX_W'(BEATS-1)) begin
                    state_d = IDLE;
                end
            end
            RD: begin
                // SRAM data lags its address by one cycle, so beat b lands while b+1 is issued
                if (b_q != '0) begin
                    asm_d[BEAT_W*(b_q - BIDX_W'(1)) +: BEAT_W] = mem_rdata;
                end
                b_d = b_q + BIDX_W'(1);
                if (b_q == BIDX_W'(BEATS-1)) begin
                    state_d = RD_LAST;
                end
            end
            RD_LAST: begin
                read_data_d = {mem_rdata, asm_q[LINE_W-BEAT_W-1:0]};
                rvalid_d    = 1'b1;
                b_d         = '0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // SRAM pins are registered from the next-state view so they change only on clk
        mem_addr_d  = '0;
        mem_be_d    = '0;
        mem_wdata_d = '0;
        if (state_d == WR) begin
            mem_addr_d  = {addr_d, b_d};
            mem_be_d    = be_d[BE_W*b_d +: BE_W];
            mem_wdata_d = beat_slice(line_d, b_d);
        end else if (state_d == RD) begin
            mem_addr_d  = {addr_d, b_d};
        end
        mem_we_d = |mem_be_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            b_q         <= '0;
            addr_q      <= '0;
            be_q        <= '0;
            line_q      <= '0;
            asm_q       <= '0;
            read_data_q <= '0;
            rvalid_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            b_q         <= b_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            line_q      <= line_d;
            asm_q       <= asm_d;
            read_data_q <= read_data_d;
            rvalid_q    <= rvalid_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign readData  = read_data_q;
    assign rvalid    = rvalid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: doc/vram_line_responder.md
# vram_line_responder

Memory-side responder for the processor's 256-bit RAM request port (rden/wren, 14-bit line address, 32-bit byte enable, 256-bit write/read data). It services each line request by serialising it into eight 32-bit beats on a narrow synchronous single-port SRAM. It reassembles read beats into a full line and signals busy while a request is in flight. It sits between the datapath's load/store unit and the backing SRAM macro.

## Interface
Parameters:
- ADDR_W, 14, line address width
- LINE_W, 256, line width in bits
- BEAT_W, 32, SRAM data width; BEATS = LINE_W/BEAT_W = 8, BIDX_W = 3

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low; resets the block when 0
- rden  in  1  line read request
- wren  in  1  line write request
- address  in  ADDR_W  line address
- byteena  in  LINE_W/8  byte enables for writes; bit k covers writeData[8k+7:8k]
- writeData  in  LINE_W  write line
- readData  out  LINE_W  last completed read line
- rvalid  out  1  one-cycle pulse when readData is updated
- busy  out  1  request in flight; new requests ignored
- mem_addr  out  ADDR_W+BIDX_W  SRAM word address {line, beat}
- mem_we  out  1  SRAM write strobe
- mem_be  out  BEAT_W/8  SRAM byte enables
- mem_wdata  out  BEAT_W  SRAM write data
- mem_rdata  in  BEAT_W  SRAM read data, valid one cycle after its address is sampled

## Operation
- FSM states: IDLE, WR, RD, RD_LAST. busy = (state != IDLE), registered-state decode.
- IDLE: if wren=1, capture address, byteena and writeData, then go to WR. Else if rden=1, capture address and go to RD. wren has priority when both are 1; rden is dropped.
- Requests while busy=1 are ignored. The initiator holds off until busy=0.
- WR: beat counter b counts 0..7.
  - mem_addr={addr,b}, mem_wdata=line[32b+31:32b], mem_be=byteena[4b+3:4b], mem_we=|mem_be.
  - A beat with an all-zero enable is issued with mem_we=0.
  - After b=7, go to IDLE.
- RD: issue mem_addr={addr,b} with mem_we=0 and mem_be=0 for b=0..7.
  - The beat returned one cycle later is written into assembly register slot [32(b-1)+31:32(b-1)].
  - After b=7, go to RD_LAST.
- RD_LAST: capture the final beat into slot 7. Load the full line into readData, pulse rvalid, go to IDLE.
- readData holds its value until the next read completes. Writes never change readData.
- byteena is ignored for reads.
- Outside WR and RD: mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
- Reset (asynchronous, any state): state=IDLE, counter=0, readData=0, rvalid=0, busy=0, all mem_* outputs 0.
  - A write aborted by reset leaves SRAM partially updated. This is accepted and not undone.
  - An aborted read produces no rvalid.

## Timing
- Request sampled at edge E0; busy is high from E0.
- Write: beat b is presented between E(b) and E(b+1) and written at E(b+1). busy falls after E8, so a write occupies 8 cycles.
- Read: beat b data is captured at E(b+2). readData and rvalid are updated at E9; rvalid is high for the single cycle E9–E10. busy falls after E9, so a read occupies 9 cycles.
- Earliest next request is sampled at E8 (after a write) or E9 (after a read).
- Back-to-back requests with no idle cycle are legal.
- Throughput: one line per 8 or 9 cycles.

## Structure
- Package vram_pkg holds:
  - the state enum (IDLE, WR, RD, RD_LAST)
  - BEATS, BIDX_W
  - a beat-slice function returning line[BEAT_W*b +: BEAT_W]
- Single module, no sub-modules.
- The bench supplies a behavioural 32-bit, 1R/W, 1-cycle-latency SRAM model sram_beat_model with 2^(ADDR_W+3) words.

## Test plan
- Full write then read: write line 0x0005 = {8 words 0x11111111..0x88888888}, byteena all ones; read 0x0005.
  - Required: SRAM words 0x28..0x2F are written at E1..E8.
  - Required: rvalid at E9 of the read, with readData equal to the written line.
- Partial write: byteena=0x0000000F over a preloaded line of 0xFFFFFFFF, writing 0xAABBCCDD in word 0.
  - Required: only beat 0 has mem_we=1.
  - Required: the following read returns word0=0xAABBCCDD and words 1–7=0xFFFFFFFF.
- Simultaneous request: rden=wren=1 at address 0x3FFF (top address).
  - Required: a write occurs at mem_addr 0x1FFF8..0x1FFFF.
  - Required: no rvalid; busy is high for exactly 8 cycles.
- Request while busy: pulse rden at address 0x0001 during cycle 3 of a write.
  - Required: no extra SRAM activity and no rvalid.
  - Required: a read issued at E8 is accepted immediately.
- Reset mid-read: drop reset to 0 at cycle 5 of a read.
  - Required: busy=0, readData=0, mem_* outputs 0, and no rvalid.
  - Required: a subsequent read returns correct data.
